booth_mult_seq: RTL and testbench
=================================

BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 Parameter WIDTH_A, default 32, multiplicand and result width; SHALL be >= 4.
REQ-002 Parameter WIDTH_B, default 16, multiplier width; SHALL be even and >= 4.
REQ-003 Derived constant N = WIDTH_B/2 + 1 SHALL be the number of Booth digits and accumulate cycles (N = 9 at defaults).
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 ctrl_RESETn  input  1  reset, synchronous and active-low.
REQ-006 ctrl_MULT  input  1  start request, sampled on rising edge.
REQ-007 ctrl_SIGNED  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-008 data_operandA  input  WIDTH_A  multiplicand.
REQ-009 data_operandB  input  WIDTH_B  multiplier.
REQ-010 data_result  output  WIDTH_A  low WIDTH_A bits of product, registered.
REQ-011 data_exception  output  1  product not representable in WIDTH_A bits for the latched mode, registered.
REQ-012 data_inputRDY  output  1  block accepts a start this cycle.
REQ-013 data_resultRDY  output  1  data_result/data_exception valid for the last accepted operation.

Function
REQ-014 Block SHALL be a three-state FSM: IDLE, RUN, DONE.
REQ-015 data_inputRDY SHALL be 1 in IDLE and DONE, 0 in RUN (decoded from state only).
REQ-016 Start SHALL be accepted on an edge where ctrl_MULT=1 and data_inputRDY=1: latch operandA, operandB, ctrl_SIGNED; clear accumulator and digit counter; go to RUN; data_resultRDY -> 0.
REQ-017 ctrl_MULT in RUN SHALL be ignored; operand inputs SHALL be don't-care after the start edge.
REQ-018 In RUN, each edge SHALL add one radix-4 Booth partial product (digit from bits 2i+1, 2i, 2i-1 of B extended by one bit: sign bit if signed, 0 if unsigned; bit -1 = 0), digit set {-2,-1,0,+1,+2} times A, shifted left 2i, into an accumulator of width >= WIDTH_A+WIDTH_B+2.
REQ-019 A SHALL be sign-extended in signed mode, zero-extended in unsigned mode, before scaling.
REQ-020 After the N-th RUN edge (N edges after the start edge) state SHALL be DONE, data_result = accumulator[WIDTH_A-1:0], data_resultRDY = 1; latency fixed at N edges for all operand values.
REQ-021 Signed mode: data_exception SHALL be 1 iff accumulator bits [WIDTH_A+WIDTH_B-1:WIDTH_A-1] are not all equal.
REQ-022 Unsigned mode: data_exception SHALL be 1 iff accumulator bits [WIDTH_A+WIDTH_B-1:WIDTH_A] are not all zero.
REQ-023 data_result and data_exception SHALL change only on the completion edge and on reset; held through DONE and through the following RUN.
REQ-024 DONE SHALL persist until a new start is accepted; a start in DONE SHALL behave per REQ-016 (resultRDY drops the next cycle, no idle gap).
REQ-025 Zero operand SHALL yield result 0, exception 0, same latency.

Reset
REQ-026 ctrl_RESETn=0 at a rising edge SHALL force state IDLE, counter 0, accumulator 0, data_result 0, data_exception 0, data_resultRDY 0; data_inputRDY = 1.
REQ-027 Reset SHALL take priority over ctrl_MULT on the same edge; a start is not accepted while ctrl_RESETn=0.
REQ-028 Reset mid-RUN SHALL discard the operation; no data_resultRDY pulse SHALL follow.

Verification (WIDTH_A=32, WIDTH_B=16, N=9)
REQ-029 Signed, A=7, B=0xFFFD (-3), start -> after 9 edges resultRDY=1, result=0xFFFFFFEB, exception=0; inputRDY=0 for exactly those 9 cycles.
REQ-030 Signed, A=0x7FFFFFFF, B=2 -> result=0xFFFFFFFE, exception=1.
REQ-031 Unsigned, A=0xFFFFFFFF, B=0xFFFF -> result=0xFFFF0001, exception=1; same operands signed -> result=0x00000001, exception=0.
REQ-032 Signed, A=0x00010000, B=0x8000 (-32768) -> result=0x80000000, exception=0 (representable boundary).
REQ-033 Start A=3,B=5; hold ctrl_MULT=1 with A=9,B=9 during RUN -> result=15 after 9 edges; in DONE a new start is accepted immediately, resultRDY=0 next cycle, then result=81 after 9 more edges.
REQ-034 Start A=3,B=5, drive ctrl_RESETn=0 at the 4th RUN edge -> next cycle result=0, exception=0, resultRDY=0, inputRDY=1; no resultRDY for at least 12 subsequent edges without a new start.

Source files
------------

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-4 Booth multiplier, one partial product per clock.
module booth_mult_seq #(
  parameter int WIDTH_A = 32,
  parameter int WIDTH_B = 16
) (
  input  logic               clock,
  input  logic               ctrl_RESETn,
  input  logic               ctrl_MULT,
  input  logic               ctrl_SIGNED,
  input  logic [WIDTH_A-1:0] data_operandA,
  input  logic [WIDTH_B-1:0] data_operandB,
  output logic [WIDTH_A-1:0] data_result,
  output logic               data_exception,
  output logic               data_inputRDY,
  output logic               data_resultRDY
);
  localparam int N     = WIDTH_B / 2 + 1;
  localparam int ACC_W = WIDTH_A + WIDTH_B + 2;
  localparam int BX_W  = WIDTH_B + 3;
  localparam int CW    = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc, acc_nxt, a_sh, pp;
  logic [BX_W-1:0]   bx;
  logic [CW-1:0]     cnt;
  logic              sgn, start, last, exc_nxt;
  logic [2:0]        d;
  logic [WIDTH_B:0]  top;
  assign data_inputRDY  = state != RUN;
  assign data_resultRDY = state == DONE;
  assign start = ctrl_MULT & data_inputRDY;
  assign last  = state == RUN && cnt == CW'(N - 1);
  always_ff @(posedge clock) begin
    if (!ctrl_RESETn) state <= IDLE;
    else              state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    if (state == RUN) state_nxt = last ? DONE : RUN;
    else if (start)   state_nxt = RUN;
  end
  // bx holds B with a trailing 0 (bit -1) and two extension bits; bx[2:0] is the current digit window
  always_comb begin
    d       = bx[2:0];
    pp      = (d == 3'b011) ? a_sh << 1 :
              (d == 3'b100) ? -(a_sh << 1) :
              (d == 3'b001 || d == 3'b010) ? a_sh :
              (d == 3'b101 || d == 3'b110) ? -a_sh : '0;
    acc_nxt = acc + pp;
    top     = acc_nxt[WIDTH_A+WIDTH_B-1:WIDTH_A-1];
    exc_nxt = sgn ? !(&top || ~|top) : |top[WIDTH_B:1];
  end
  always_ff @(posedge clock) begin
    if (!ctrl_RESETn) begin
      acc            <= '0;
      a_sh           <= '0;
      bx             <= '0;
      cnt            <= '0;
      sgn            <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      acc  <= '0;
      cnt  <= '0;
      sgn  <= ctrl_SIGNED;
      a_sh <= {{(ACC_W-WIDTH_A){ctrl_SIGNED & data_operandA[WIDTH_A-1]}}, data_operandA};
      bx   <= {{2{ctrl_SIGNED & data_operandB[WIDTH_B-1]}}, data_operandB, 1'b0};
    end else if (state == RUN) begin
      acc  <= acc_nxt;
      cnt  <= cnt + 1'b1;
      a_sh <= a_sh << 2;
      bx   <= {{2{bx[BX_W-1]}}, bx[BX_W-1:2]};
      if (last) begin
        data_result    <= acc_nxt[WIDTH_A-1:0];
        data_exception <= exc_nxt;
      end
    end
  end
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: random and directed operands checked against a plain-arithmetic product model.
module tb_booth_mult_seq;
  logic        clock = 0, ctrl_RESETn = 0, ctrl_MULT = 0, ctrl_SIGNED = 0;
  logic [31:0] data_operandA = 0, data_result;
  logic [15:0] data_operandB = 0;
  logic        data_exception, data_inputRDY, data_resultRDY;
  int          n_vec = 0, n_err = 0;

  booth_mult_seq dut (
    .clock(clock), .ctrl_RESETn(ctrl_RESETn), .ctrl_MULT(ctrl_MULT), .ctrl_SIGNED(ctrl_SIGNED),
    .data_operandA(data_operandA), .data_operandB(data_operandB), .data_result(data_result),
    .data_exception(data_exception), .data_inputRDY(data_inputRDY), .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input bit s, input logic [31:0] a, input logic [15:0] b,
                                output logic [31:0] r, output bit e);
    longint p;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'({32'b0, a}) * longint'({48'b0, b});
    r = p[31:0];
    e = s ? (p < -longint'(64'h80000000) || p > longint'(64'h7FFFFFFF)) : (p > longint'(64'hFFFFFFFF));
  endfunction

  // Called #1 after an edge; starts an op, watches the 9 RUN cycles, checks the result.
  // With hold set, ctrl_MULT stays high and operands become 9/9 during RUN.
  task automatic do_op(input bit s, input logic [31:0] a, input logic [15:0] b, input bit hold);
    logic [31:0] r, prev;
    bit e, prev_e;
    model(s, a, b, r, e);
    prev = data_result;
    prev_e = data_exception;
    ctrl_SIGNED = s; data_operandA = a; data_operandB = b; ctrl_MULT = 1;
    @(posedge clock); #1;
    ctrl_MULT = hold;
    data_operandA = hold ? 32'd9 : $urandom;
    data_operandB = hold ? 16'd9 : 16'($urandom);
    ctrl_SIGNED = 1'($urandom);
    for (int k = 0; k < 9; k++) begin
      check("in_rdy", data_inputRDY, 0);
      check("res_rdy", data_resultRDY, 0);
      check("held", {data_exception, data_result}, {prev_e, prev});
      @(posedge clock); #1;
    end
    check("done_rdy", data_resultRDY, 1);
    check("done_in_rdy", data_inputRDY, 1);
    check("result", data_result, r);
    check("exception", data_exception, e);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst_result", data_result, 0);
    check("rst_exc", data_exception, 0);
    check("rst_res_rdy", data_resultRDY, 0);
    check("rst_in_rdy", data_inputRDY, 1);
    ctrl_RESETn = 1;
    @(posedge clock); #1;
    do_op(1, 32'd7, 16'hFFFD, 0);
    do_op(1, 32'h7FFFFFFF, 16'd2, 0);
    do_op(0, 32'hFFFFFFFF, 16'hFFFF, 0);
    do_op(1, 32'hFFFFFFFF, 16'hFFFF, 0);
    do_op(1, 32'h00010000, 16'h8000, 0);
    do_op(1, 32'h00010000, 16'h7FFF, 0);
    do_op(0, 32'h00010000, 16'hFFFF, 0);
    do_op(0, 32'h00010000, 16'h0001, 0);
    do_op(1, 32'h80000000, 16'hFFFF, 0);
    do_op(1, 32'h80000000, 16'h0001, 0);
    do_op(0, 32'h0, 16'hFFFF, 0);
    do_op(1, 32'hDEADBEEF, 16'h0, 0);
    repeat (3) @(posedge clock);
    #1;
    check("idle_in_rdy", data_inputRDY, 1);
    do_op(0, 32'd3, 16'd5, 1);
    do_op(0, 32'd9, 16'd9, 0);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [15:0] b;
      a = $urandom;
      b = 16'($urandom);
      if (i % 4 == 1) a = {{20{a[31]}}, a[11:0]};
      if (i % 4 == 2) b = {{10{b[15]}}, b[5:0]};
      do_op(1'($urandom), a, b, 0);
    end
    // reset at the 4th RUN edge, with a start request present on that edge
    ctrl_SIGNED = 0; data_operandA = 3; data_operandB = 5; ctrl_MULT = 1;
    @(posedge clock); #1;
    ctrl_MULT = 0;
    repeat (3) @(posedge clock);
    #1;
    ctrl_RESETn = 0; ctrl_MULT = 1;
    @(posedge clock); #1;
    check("mid_rst_result", data_result, 0);
    check("mid_rst_exc", data_exception, 0);
    check("mid_rst_res_rdy", data_resultRDY, 0);
    check("mid_rst_in_rdy", data_inputRDY, 1);
    ctrl_MULT = 0;
    @(posedge clock); #1;
    ctrl_RESETn = 1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock); #1;
      check("no_res_rdy", data_resultRDY, 0);
      check("stay_idle", data_inputRDY, 1);
    end
    do_op(1, 32'hFFFFFFF0, 16'h0003, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
